// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the data-memory arbiter
package mem_arbiter_pkg;

    // Sequencer states: grant in IDLE, drive MEM in ACCESS, hold response in RESP.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // MEM size codes, forwarded untouched to memControl.
    localparam logic [2:0] MEM_BYTE   = 3'd0;
    localparam logic [2:0] MEM_HALF   = 3'd1;
    localparam logic [2:0] MEM_WORD   = 3'd2;
    localparam logic [2:0] MEM_DWORD  = 3'd3;
    localparam logic [2:0] MEM_BYTE_U = 3'd4;
    localparam logic [2:0] MEM_HALF_U = 3'd5;
    localparam logic [2:0] MEM_WORD_U = 3'd6;

    // Requester identifiers as stored in the command register.
    localparam logic PORT_PIPE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    // One-hot mask for a single-bit port id.
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_LOADER) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    // A lone requester wins; on a tie the port that was not granted last wins.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_grant == PORT_LOADER) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and sequencer for the shared data memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_addr,
    input  logic [WIDTH-1:0] r0_wdata,
    input  logic             r0_write,
    input  logic [2:0]       r0_ctrl,
    output logic             r0_rvalid,
    output logic [WIDTH-1:0] r0_rdata,
    input  logic             r0_rready,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_addr,
    input  logic [WIDTH-1:0] r1_wdata,
    input  logic             r1_write,
    input  logic [2:0]       r1_ctrl,
    output logic             r1_rvalid,
    output logic [WIDTH-1:0] r1_rdata,
    input  logic             r1_rready,

    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       mem_ctrl,
    input  logic [WIDTH-1:0] mem_rdata
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;

    logic             r_last_grant;
    logic [WIDTH-1:0] r_cmd_addr;
    logic [WIDTH-1:0] r_cmd_wdata;
    logic             r_cmd_write;
    logic [2:0]       r_cmd_ctrl;
    logic             r_cmd_port;
    logic [WIDTH-1:0] r_rdata;

    logic [1:0]       w_gnt;
    logic             w_arb_en;
    logic             w_grant;
    logic             w_winner;
    logic             w_access;
    logic [1:0]       w_rvalid;
    logic             w_resp_done;

    logic [WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0] w_sel_wdata;
    logic             w_sel_write;
    logic [2:0]       w_sel_ctrl;

    // Grants are only offered while idle and out of reset.
    assign w_arb_en = (r_state == ARB_IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .req        ({r1_valid, r0_valid}),
        .last_grant (r_last_grant),
        .en         (w_arb_en),
        .gnt        (w_gnt)
    );

    assign w_grant  = |w_gnt;
    assign w_winner = w_gnt[1];
    assign r0_ready = w_gnt[0];
    assign r1_ready = w_gnt[1];

    // Route the winning port's request fields toward the command register.
    always_comb begin
        w_sel_addr  = r0_addr;
        w_sel_wdata = r0_wdata;
        w_sel_write = r0_write;
        w_sel_ctrl  = r0_ctrl;
        if (w_winner) begin
            w_sel_addr  = r1_addr;
            w_sel_wdata = r1_wdata;
            w_sel_write = r1_write;
            w_sel_ctrl  = r1_ctrl;
        end
    end

    // Response valid goes only to the owner; reset masks it so a dropped response never shows.
    always_comb begin
        w_rvalid = 2'b00;
        if ((r_state == ARB_RESP) && !rst) begin
            w_rvalid = port_onehot(r_cmd_port);
        end
    end

    assign w_resp_done = |(w_rvalid & {r1_rready, r0_rready});

    assign r0_rvalid = w_rvalid[0];
    assign r1_rvalid = w_rvalid[1];
    assign r0_rdata  = w_rvalid[0] ? r_rdata : '0;
    assign r1_rdata  = w_rvalid[1] ? r_rdata : '0;

    // MEM strobes last exactly the ACCESS cycle; rst gating keeps an interrupted store from committing.
    assign w_access  = (r_state == ARB_ACCESS) && !rst;
    assign mem_read  = w_access && !r_cmd_write;
    assign mem_write = w_access && r_cmd_write;
    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;
    assign mem_ctrl  = r_cmd_ctrl;

    // Next-state logic: grant -> one access cycle -> hold response until the owner takes it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant) begin
                    w_next_state = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                w_next_state = ARB_RESP;
            end
            ARB_RESP: begin
                if (w_resp_done) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // State register, command capture on grant, and load data capture at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= PORT_LOADER;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cmd_write  <= 1'b0;
            r_cmd_ctrl   <= '0;
            r_cmd_port   <= PORT_PIPE;
            r_rdata      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_cmd_addr   <= w_sel_addr;
                r_cmd_wdata  <= w_sel_wdata;
                r_cmd_write  <= w_sel_write;
                r_cmd_ctrl   <= w_sel_ctrl;
                r_cmd_port   <= w_winner;
                r_last_grant <= w_winner;
            end
            if (r_state == ARB_ACCESS) begin
                r_rdata <= r_cmd_write ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction model
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  v  = 2'b00;
    logic [1:0]  wr = 2'b00;
    logic [1:0]  rr = 2'b00;
    logic [63:0] ad [2];
    logic [63:0] wd [2];
    logic [2:0]  ct [2];

    logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [63:0] r0_rdata, r1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_ctrl;
    logic [1:0]  w_ready, w_rvalid;
    assign w_ready  = {r1_ready, r0_ready};
    assign w_rvalid = {r1_rvalid, r0_rvalid};

    mem_arbiter #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(v[0]), .r0_ready(r0_ready), .r0_addr(ad[0]), .r0_wdata(wd[0]),
        .r0_write(wr[0]), .r0_ctrl(ct[0]), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r0_rready(rr[0]),
        .r1_valid(v[1]), .r1_ready(r1_ready), .r1_addr(ad[1]), .r1_wdata(wd[1]),
        .r1_write(wr[1]), .r1_ctrl(ct[1]), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .r1_rready(rr[1]),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata)
    );

    function automatic int nbytes(input logic [2:0] c);
        case (c)
            MEM_BYTE, MEM_BYTE_U: return 1;
            MEM_HALF, MEM_HALF_U: return 2;
            MEM_WORD, MEM_WORD_U: return 4;
            MEM_DWORD:            return 8;
            default:              return 0;
        endcase
    endfunction

    // raw holds 8 bytes big-endian starting at the access address.
    function automatic logic [63:0] decode(input logic [63:0] raw, input logic [2:0] c);
        case (c)
            MEM_BYTE:   return {{56{raw[63]}}, raw[63:56]};
            MEM_HALF:   return {{48{raw[63]}}, raw[63:48]};
            MEM_WORD:   return {{32{raw[63]}}, raw[63:32]};
            MEM_DWORD:  return raw;
            MEM_BYTE_U: return {56'd0, raw[63:56]};
            MEM_HALF_U: return {48'd0, raw[63:48]};
            MEM_WORD_U: return {32'd0, raw[63:32]};
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [63:0] d, input int n, input int i);
        logic [63:0] s;
        s = d >> (8 * (n - 1 - i));
        return s[7:0];
    endfunction

    // Behavioural MEM seen by the DUT.
    logic [7:0]  dev_mem [256];
    logic [63:0] dev_raw;
    always_comb begin
        dev_raw = 64'd0;
        for (int i = 0; i < 8; i++) dev_raw = {dev_raw[55:0], dev_mem[mem_addr[7:0] + 8'(i)]};
        mem_rdata = mem_read ? decode(dev_raw, mem_ctrl) : 64'd0;
    end
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= 8'h00;
        end else if (mem_write) begin
            for (int i = 0; i < 8; i++)
                if (i < nbytes(mem_ctrl))
                    dev_mem[mem_addr[7:0] + 8'(i)] <= byte_of(mem_wdata, nbytes(mem_ctrl), i);
        end
    end

    // Reference memory and transaction-level model.
    logic [7:0]  ref_mem [256];
    int          total = 0;
    int          bad = 0;
    int          m_busy = 0, m_owner = 0, m_age = 0, m_last = 1, m_acc = -1, m_done = 0;
    logic        m_wr;
    logic [63:0] m_addr, m_wdata, m_exp, m_resp;
    logic [2:0]  m_ctrl;
    int          acc_q[$];
    int          cyc_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs driven; checks this cycle, advances one clock.
    task automatic cycle_check();
        int win;
        logic [63:0] raw;
        logic [63:0] own_rdata;
        #1;
        win = -1;
        m_acc = -1;
        if (rst) begin
            chk("rst_ready", 64'(w_ready), 64'd0);
            chk("rst_rvalid", 64'(w_rvalid), 64'd0);
            chk("rst_mem_rw", 64'({mem_read, mem_write}), 64'd0);
        end else if (m_busy == 0) begin
            if (v == 2'b01) win = 0;
            else if (v == 2'b10) win = 1;
            else if (v == 2'b11) win = 1 - m_last;
            chk("grant", 64'(w_ready), (win < 0) ? 64'd0 : (64'd1 << win));
            chk("idle_rvalid", 64'(w_rvalid), 64'd0);
            chk("idle_mem_rw", 64'({mem_read, mem_write}), 64'd0);
        end else if (m_age == 1) begin
            chk("access_ready", 64'(w_ready), 64'd0);
            chk("access_rvalid", 64'(w_rvalid), 64'd0);
            chk("mem_read", 64'(mem_read), 64'(!m_wr));
            chk("mem_write", 64'(mem_write), 64'(m_wr));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_ctrl", 64'(mem_ctrl), 64'(m_ctrl));
            chk("mem_wdata", mem_wdata, m_wdata);
            if (m_wr) begin
                for (int i = 0; i < nbytes(m_ctrl); i++)
                    ref_mem[m_addr[7:0] + 8'(i)] = byte_of(m_wdata, nbytes(m_ctrl), i);
                m_exp = 64'd0;
            end else begin
                raw = 64'd0;
                for (int i = 0; i < 8; i++) raw = {raw[55:0], ref_mem[m_addr[7:0] + 8'(i)]};
                m_exp = decode(raw, m_ctrl);
            end
        end else begin
            own_rdata = (m_owner == 0) ? r0_rdata : r1_rdata;
            chk("resp_ready", 64'(w_ready), 64'd0);
            chk("resp_rvalid", 64'(w_rvalid), 64'd1 << m_owner);
            chk("resp_rdata", own_rdata, m_exp);
            chk("resp_mem_rw", 64'({mem_read, mem_write}), 64'd0);
            if (rr[m_owner]) m_resp = own_rdata;
        end
        @(posedge clk);
        if (rst) begin
            m_busy = 0;
            m_last = 1;
        end else if (m_busy == 0) begin
            if (win >= 0) begin
                m_busy = 1; m_age = 1; m_owner = win; m_last = win; m_acc = win;
                m_wr = wr[win]; m_addr = ad[win]; m_wdata = wd[win]; m_ctrl = ct[win];
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (rr[m_owner]) begin
            m_busy = 0;
            m_done++;
        end
        @(negedge clk);
        if (m_acc >= 0) v[m_acc] = 1'b0;
    endtask

    task automatic txn(input int p, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic [2:0] c);
        int d0;
        int n;
        v[p] = 1'b1; wr[p] = w; ad[p] = a; wd[p] = d; ct[p] = c; rr[p] = 1'b1;
        d0 = m_done;
        n = 0;
        while (m_done == d0 && n < 20) begin
            cycle_check();
            n++;
        end
        chk("txn_done", 64'(m_done - d0), 64'd1);
        chk("txn_latency", 64'(n), 64'd3);
    endtask

    task automatic drain();
        int n;
        v = 2'b00;
        rr = 2'b11;
        n = 0;
        while (m_busy != 0 && n < 20) begin
            cycle_check();
            n++;
        end
        chk("drain", 64'(m_busy), 64'd0);
    endtask

    task automatic do_reset();
        v = 2'b00;
        rst = 1'b1;
        cycle_check();
        cycle_check();
        rst = 1'b0;
    endtask

    task automatic set_load_both(input logic [63:0] a);
        for (int k = 0; k < 2; k++) begin
            wr[k] = 1'b0; ad[k] = a; wd[k] = 64'd0; ct[k] = MEM_DWORD;
        end
    endtask

    initial begin
        int d0;
        int off;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            ad[k] = 64'd0; wd[k] = 64'd0; ct[k] = 3'd0;
        end
        @(negedge clk);
        cycle_check();
        cycle_check();
        rst = 1'b0;
        mem_init = 1'b0;
        chk("reset_outputs", 64'({r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_read, mem_write}), 64'd0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        chk("reset_mem_wdata", mem_wdata, 64'd0);
        chk("reset_mem_ctrl", 64'(mem_ctrl), 64'd0);
        chk("reset_rdata", r0_rdata | r1_rdata, 64'd0);

        txn(0, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, MEM_DWORD);
        txn(0, 1'b0, 64'h40, 64'd0, MEM_DWORD);
        chk("store_load_p0", m_resp, 64'hDEADBEEF_CAFEF00D);

        do_reset();
        set_load_both(64'h40);
        rr = 2'b11;
        for (int c = 0; c < 12; c++) begin
            v = 2'b11;
            cycle_check();
            if (m_acc >= 0) begin
                acc_q.push_back(m_acc);
                cyc_q.push_back(c);
            end
        end
        drain();
        chk("tie_count", 64'(acc_q.size()), 64'd4);
        if (acc_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("tie_order", 64'(acc_q[k]), 64'(k % 2));
            for (int k = 0; k < 2; k++) chk("tie_wait_le6", 64'(cyc_q[k + 2] - cyc_q[k] <= 6), 64'd1);
        end

        rr = 2'b00;
        v[1] = 1'b1; wr[1] = 1'b0; ad[1] = 64'h40; ct[1] = MEM_DWORD;
        cycle_check();
        chk("bp_accept", 64'(m_acc), 64'd1);
        v[0] = 1'b1; wr[0] = 1'b0; ad[0] = 64'h48; ct[0] = MEM_DWORD; rr[0] = 1'b1;
        cycle_check();
        for (int k = 0; k < 5; k++) cycle_check();
        chk("bp_held_data", r1_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("bp_held_ready0", 64'(r0_ready), 64'd0);
        d0 = m_done;
        rr[1] = 1'b1;
        cycle_check();
        chk("bp_complete", 64'(m_done - d0), 64'd1);
        cycle_check();
        chk("bp_next_p0", 64'(m_acc), 64'd0);
        drain();

        txn(1, 1'b1, 64'h0, 64'h80FF_0000_0000_0001, MEM_DWORD);
        txn(1, 1'b0, 64'h0, 64'd0, MEM_BYTE);
        chk("sext_byte", m_resp, 64'hFFFF_FFFF_FFFF_FF80);
        txn(0, 1'b0, 64'h0, 64'd0, MEM_BYTE_U);
        chk("zext_byte", m_resp, 64'h80);

        txn(0, 1'b1, 64'h80, 64'h1111, MEM_DWORD);
        v[0] = 1'b1; wr[0] = 1'b1; ad[0] = 64'h80; wd[0] = 64'h2222; ct[0] = MEM_DWORD; rr[0] = 1'b1;
        cycle_check();
        rst = 1'b1;
        cycle_check();
        rst = 1'b0;
        chk("rst_mid_outputs", 64'({r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_read, mem_write}), 64'd0);
        chk("rst_mid_mem_addr", mem_addr, 64'd0);
        chk("rst_mid_rdata", r0_rdata | r1_rdata, 64'd0);
        set_load_both(64'h40);
        v = 2'b11;
        cycle_check();
        chk("rst_tie_p0", 64'(m_acc), 64'd0);
        drain();
        txn(1, 1'b0, 64'h80, 64'd0, MEM_DWORD);
        chk("rst_no_commit", m_resp, 64'h1111);

        txn(0, 1'b0, 64'h40, 64'd0, 3'b111);
        chk("bad_ctrl_load", m_resp, 64'd0);
        txn(0, 1'b1, 64'h40, 64'h5555, 3'b111);
        txn(0, 1'b0, 64'h40, 64'd0, MEM_DWORD);
        chk("bad_ctrl_store", m_resp, 64'hDEADBEEF_CAFEF00D);

        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!v[p] && $urandom_range(0, 2) == 0) begin
                    v[p] = 1'b1;
                    wr[p] = ($urandom_range(0, 2) == 0);
                    wd[p] = {$urandom, $urandom};
                    if (wr[p]) begin
                        ct[p] = MEM_DWORD;
                        ad[p] = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
                    end else begin
                        ct[p] = 3'($urandom_range(0, 7));
                        off = (nbytes(ct[p]) == 0) ? 0 :
                              ($urandom_range(0, 7) / nbytes(ct[p])) * nbytes(ct[p]);
                        ad[p] = {56'd0, 5'($urandom_range(0, 31)), 3'b000} + 64'(off);
                    end
                end
            end
            rr = 2'($urandom_range(0, 3));
            cycle_check();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 64-bit data memory (MEM).
- Port 0 is the pipeline load/store path; port 1 is the loader/debug path, which preloads and inspects data memory.
- Accepts one request at a time via valid/ready and grants with round-robin on contention.
- Drives MEM's address, data, MemRead/MemWrite and memControl for exactly one cycle, then returns a registered response with a valid/ready handshake.

Parameters:
- WIDTH, 64, data and address width; matches MEM.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- r0_valid  in  1  port 0 request valid
- r0_ready  out  1  port 0 request accepted this cycle
- r0_addr  in  WIDTH  port 0 byte address
- r0_wdata  in  WIDTH  port 0 store data
- r0_write  in  1  1=store, 0=load
- r0_ctrl  in  3  port 0 size code (`MEM_BYTE .. `MEM_DWORD, from parameters.vh)
- r0_rvalid  out  1  port 0 response valid
- r0_rdata  out  WIDTH  port 0 load data (0 for stores)
- r0_rready  in  1  port 0 response consumed
- r1_valid, r1_ready, r1_addr, r1_wdata, r1_write, r1_ctrl, r1_rvalid, r1_rdata, r1_rready: same as port 0, for port 1
- mem_addr  out  WIDTH  to MEM byte_address
- mem_wdata  out  WIDTH  to MEM data_write
- mem_read  out  1  to MEM MemRead
- mem_write  out  1  to MEM MemWrite
- mem_ctrl  out  3  to MEM memControl
- mem_rdata  in  WIDTH  from MEM data_read (combinational)

Behaviour:
- States: IDLE, ACCESS, RESP.
- IDLE: rN_ready is combinational and asserted only to the arbitration winner. When a grant occurs:
  - capture addr, wdata, write, ctrl and port id into the cmd register;
  - set last_grant to the winning port;
  - go to ACCESS.
- Arbitration:
  - only one port valid -> that port wins;
  - both valid -> the port != last_grant wins;
  - last_grant resets to 1, so port 0 wins the first tie.
- ACCESS (exactly one cycle):
  - mem_read = !cmd_write; mem_write = cmd_write; both are gated with !rst, combinationally;
  - mem_addr/mem_wdata/mem_ctrl come from the cmd register;
  - the store commits at the ACCESS->RESP edge;
  - load data: rdata_q <= mem_rdata at the same edge; stores: rdata_q <= 0;
  - next state RESP.
- RESP:
  - rN_rvalid=1 for the owning port only; rN_rdata = rdata_q;
  - hold until rN_rready=1, then go to IDLE;
  - no request is accepted in RESP, so all rN_ready=0.
- Latency:
  - request accepted at cycle T; MEM access at T+1; rvalid at T+2;
  - maximum throughput is one transaction per 3 cycles.
- Outside ACCESS: mem_read=mem_write=0; mem_addr/wdata/ctrl hold the cmd register value.
- Values passed through unchanged (alignment is MEM's contract):
  - addr, ctrl; an unsupported ctrl yields rdata 0 on loads and no change on stores, per MEM;
  - writes must be dword-aligned, and the arbiter does not check this.
- Reset state:
  - IDLE, last_grant=1, cmd register and rdata_q = 0;
  - all rN_ready, rN_rvalid, mem_read, mem_write = 0; rN_rdata=0.
- Reset mid-operation: return to IDLE; any pending response is dropped.
  - A store in ACCESS while rst=1 does not commit, because mem_write is gated.
- A non-owning port's rready is ignored. rvalid never drops before its handshake completes.
- A requester must hold valid and its fields stable until ready (AXI-style); a valid deasserted while in ACCESS/RESP has no effect.

Decomposition:
- parameters.vh: add ARB_IDLE/ARB_ACCESS/ARB_RESP state encodings (2 bits). The existing `MEM_* size codes are reused.
- Sub-module rr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last_grant, en.
  - Outputs: gnt[1:0], one-hot or zero.

Test Plan:
- Store then load, port 0: write dword 0xDEADBEEF_CAFEF00D to addr 0x40; load `MEM_DWORD from 0x40 -> r0_rdata=0xDEADBEEFCAFEF00D; rvalid at T+2; mem_write high exactly one cycle.
- Tie after reset: r0_valid=r1_valid=1 continuously, rready=1 -> grants alternate 0,1,0,1 for 4 transactions; each port is served within 6 cycles.
- Response backpressure: port 1 load with r1_rready=0 for 5 cycles -> r1_rvalid stays 1, r1_rdata stable, r0_ready=0 throughout; completes on the first r1_rready=1.
- Sign extension: dword 0x80FF... at 0x0; `MEM_BYTE addr 0x0 -> 0xFFFFFFFFFFFFFF80; `MEM_BYTE_U -> 0x80.
- Reset during ACCESS of a store to 0x80 (old value 0x1111) -> no write commits, 0x80 still reads 0x1111; after reset all outputs are 0 and the next tie goes to port 0.
- Unsupported ctrl 3'b111 load -> rdata 0, rvalid asserted normally.
